// File: rtl/mon_mem_responder_pkg.sv
// Shared types and constants for the monitor memory responder.
// FSM encoding, memory-select values and read-latency limits.
package mon_mem_responder_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_RWAIT = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    ARB   = S_ARB,
    ISSUE = S_ISSUE,
    RWAIT = S_RWAIT,
    RESP  = S_RESP,
    HOLD  = S_HOLD
  } state_t;

  localparam logic MEM_SEL_IMEM = 1'b1;
  localparam logic MEM_SEL_DMEM = 1'b0;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  typedef struct packed {
    logic        wr;
    logic        w;
    logic [31:0] adr;
    logic [31:0] data;
  } xfer_t;

  // Counter preload; out-of-range latencies clamp to the legal window.
  function automatic logic [1:0] lat_load(input int lat);
    int c;
    c = (lat < RD_LAT_MIN) ? RD_LAT_MIN :
        (lat > RD_LAT_MAX) ? RD_LAT_MAX : lat;
    return 2'(c - 1);
  endfunction

endpackage

// File: rtl/mon_mem_responder_if.sv
// Monitor-side read/write request/response bundle.
// master = monitor bus master, slave = memory responder.
interface mon_mem_responder_if;

  logic        u_read_req;
  logic        u_read_w;
  logic [31:0] u_read_adr;
  logic        read_valid;
  logic [31:0] read_data;

  logic        u_write_req;
  logic        u_write_w;
  logic [31:0] u_write_adr;
  logic [31:0] u_write_data;
  logic        write_finish;

  modport master (
    output u_read_req, u_read_w, u_read_adr,
    output u_write_req, u_write_w, u_write_adr,
    output u_write_data,
    input  read_valid, read_data, write_finish
  );

  modport slave (
    input  u_read_req, u_read_w, u_read_adr,
    input  u_write_req, u_write_w, u_write_adr,
    input  u_write_data,
    output read_valid, read_data, write_finish
  );

endinterface

// File: rtl/mon_mem_responder.sv
// Serves monitor reads/writes on imem/dmem after winning the
// shared SRAM port from the CPU via mem_req/mem_gnt.
module mon_mem_responder
  import mon_mem_responder_pkg::*;
#(
  parameter int IWIDTH = 14,
  parameter int DWIDTH = 14,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mon_mem_responder_if.slave bus,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              imem_en,
  output logic              imem_we,
  output logic [IWIDTH-1:0] imem_adr,
  output logic              dmem_en,
  output logic              dmem_we,
  output logic [DWIDTH-1:0] dmem_adr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       imem_rdata,
  input  logic [31:0]       dmem_rdata
);

  localparam logic [1:0] LAT_M1 = lat_load(RD_LAT);

  state_t      state, state_nx;
  xfer_t       lat_q;
  logic [1:0]  cnt_q;
  logic [31:0] rd_q;
  logic        issue;
  logic        resp_rd;
  logic        resp_wr;
  logic [31:0] rdata_sel;
  logic        unused_adr;

  assign unused_adr = ^lat_q.adr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Write wins a tie so queued writes land before a later read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q <= '0;
    end else if (state == IDLE) begin
      if (bus.u_write_req) begin
        lat_q.wr   <= 1'b1;
        lat_q.w    <= bus.u_write_w;
        lat_q.adr  <= bus.u_write_adr;
        lat_q.data <= bus.u_write_data;
      end else if (bus.u_read_req) begin
        lat_q.wr  <= 1'b0;
        lat_q.w   <= bus.u_read_w;
        lat_q.adr <= bus.u_read_adr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
    end else if (issue && !lat_q.wr) begin
      cnt_q <= LAT_M1;
    end else if (state == RWAIT && cnt_q != 2'd0) begin
      cnt_q <= cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_q <= '0;
    else if (resp_rd) rd_q <= rdata_sel;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.u_write_req || bus.u_read_req)
          state_nx = ARB;
      end
      ARB: begin
        if (mem_gnt)
          state_nx = (lat_q.wr || LAT_M1 == 2'd0)
                   ? RESP : RWAIT;
      end
      ISSUE: begin
        state_nx = (lat_q.wr || LAT_M1 == 2'd0)
                 ? RESP : RWAIT;
      end
      RWAIT: begin
        if (cnt_q <= 2'd1) state_nx = RESP;
      end
      RESP:    state_nx = HOLD;
      HOLD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The grant cycle in ARB is the issue cycle; no extra state is spent.
  assign issue = (state == ARB && mem_gnt) || state == ISSUE;

  always_comb begin
    mem_req   = (state == ARB);
    imem_en   = 1'b0;
    imem_we   = 1'b0;
    imem_adr  = '0;
    dmem_en   = 1'b0;
    dmem_we   = 1'b0;
    dmem_adr  = '0;
    mem_wdata = '0;
    if (issue) begin
      if (lat_q.w == MEM_SEL_IMEM) begin
        imem_en  = 1'b1;
        imem_we  = lat_q.wr;
        imem_adr = lat_q.adr[IWIDTH+1:2];
      end else begin
        dmem_en  = 1'b1;
        dmem_we  = lat_q.wr;
        dmem_adr = lat_q.adr[DWIDTH+1:2];
      end
      if (lat_q.wr) mem_wdata = lat_q.data;
    end
  end

  assign resp_rd   = (state == RESP) && !lat_q.wr;
  assign resp_wr   = (state == RESP) && lat_q.wr;
  assign rdata_sel = (lat_q.w == MEM_SEL_IMEM)
                   ? imem_rdata : dmem_rdata;

  assign bus.read_valid   = resp_rd;
  assign bus.write_finish = resp_wr;
  assign bus.read_data    = resp_rd ? rdata_sel : rd_q;

endmodule

// File: tb/tb_mon_mem_responder.sv
// Bench for mon_mem_responder: RD_LAT=1 and RD_LAT=3 instances
// with behavioural SRAMs and a queue of expected responses.
module tb_mon_mem_responder;
  import mon_mem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          wr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  mon_mem_responder_if bi0 ();
  mon_mem_responder_if bi3 ();

  logic        mreq0, gnt0, ien0, iwe0, den0, dwe0;
  logic [13:0] iadr0, dadr0;
  logic [31:0] wd0, ird0, drd0;
  logic        mreq3, gnt3, ien3, iwe3, den3, dwe3;
  logic [13:0] iadr3, dadr3;
  logic [31:0] wd3, ird3, drd3;

  mon_mem_responder #(.IWIDTH(14), .DWIDTH(14), .RD_LAT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bi0.slave),
    .mem_req(mreq0), .mem_gnt(gnt0),
    .imem_en(ien0), .imem_we(iwe0), .imem_adr(iadr0),
    .dmem_en(den0), .dmem_we(dwe0), .dmem_adr(dadr0),
    .mem_wdata(wd0), .imem_rdata(ird0), .dmem_rdata(drd0)
  );

  mon_mem_responder #(.IWIDTH(14), .DWIDTH(14), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bi3.slave),
    .mem_req(mreq3), .mem_gnt(gnt3),
    .imem_en(ien3), .imem_we(iwe3), .imem_adr(iadr3),
    .dmem_en(den3), .dmem_we(dwe3), .dmem_adr(dadr3),
    .mem_wdata(wd3), .imem_rdata(ird3), .dmem_rdata(drd3)
  );

  // SRAM models; rdata carries junk outside the valid cycle.
  logic [31:0] im0 [256];
  logic [31:0] dm0 [256];
  logic        pv0, pi0;
  logic [31:0] pd0;
  always @(posedge clk) begin
    pv0 <= 1'b0;
    if (ien0) begin
      if (iwe0) im0[iadr0[7:0]] <= wd0;
      else begin pv0 <= 1'b1; pi0 <= 1'b1; pd0 <= im0[iadr0[7:0]]; end
    end else if (den0) begin
      if (dwe0) dm0[dadr0[7:0]] <= wd0;
      else begin pv0 <= 1'b1; pi0 <= 1'b0; pd0 <= dm0[dadr0[7:0]]; end
    end
  end
  assign ird0 = (pv0 && pi0) ? pd0 : 32'hBAD0_0001;
  assign drd0 = (pv0 && !pi0) ? pd0 : 32'hBAD0_0002;

  logic [31:0] im3 [256];
  logic [31:0] dm3 [256];
  logic        v3 [3];
  logic        i3 [3];
  logic [31:0] d3 [3];
  always @(posedge clk) begin
    v3[0] <= 1'b0;
    if (ien3) begin
      if (iwe3) im3[iadr3[7:0]] <= wd3;
      else begin v3[0] <= 1'b1; i3[0] <= 1'b1; d3[0] <= im3[iadr3[7:0]]; end
    end else if (den3) begin
      if (dwe3) dm3[dadr3[7:0]] <= wd3;
      else begin v3[0] <= 1'b1; i3[0] <= 1'b0; d3[0] <= dm3[dadr3[7:0]]; end
    end
    v3[1] <= v3[0]; i3[1] <= i3[0]; d3[1] <= d3[0];
    v3[2] <= v3[1]; i3[2] <= i3[1]; d3[2] <= d3[1];
  end
  assign ird3 = (v3[2] && i3[2]) ? d3[2] : 32'hBAD3_0001;
  assign drd3 = (v3[2] && !i3[2]) ? d3[2] : 32'hBAD3_0002;

  bit sel = 1'b0;
  wire        x_ien   = sel ? ien3  : ien0;
  wire        x_iwe   = sel ? iwe3  : iwe0;
  wire        x_den   = sel ? den3  : den0;
  wire        x_dwe   = sel ? dwe3  : dwe0;
  wire [13:0] x_iadr  = sel ? iadr3 : iadr0;
  wire [13:0] x_dadr  = sel ? dadr3 : dadr0;
  wire [31:0] x_wd    = sel ? wd3   : wd0;
  wire        x_rv    = sel ? bi3.read_valid   : bi0.read_valid;
  wire        x_wf    = sel ? bi3.write_finish : bi0.write_finish;
  wire [31:0] x_rdata = sel ? bi3.read_data    : bi0.read_data;

  task automatic drive(input bit d, input bit wr, input bit req,
                       input bit w, input logic [31:0] adr,
                       input logic [31:0] data);
    if (d) begin
      if (wr) begin
        bi3.u_write_req = req; bi3.u_write_w = w;
        bi3.u_write_adr = adr; bi3.u_write_data = data;
      end else begin
        bi3.u_read_req = req; bi3.u_read_w = w; bi3.u_read_adr = adr;
      end
    end else begin
      if (wr) begin
        bi0.u_write_req = req; bi0.u_write_w = w;
        bi0.u_write_adr = adr; bi0.u_write_data = data;
      end else begin
        bi0.u_read_req = req; bi0.u_read_w = w; bi0.u_read_adr = adr;
      end
    end
  endtask

  function automatic exp_t pop_exp();
    exp_t e;
    e.wr = 1'b0; e.data = 32'hFFFF_FFFF;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  // One transfer from an IDLE cycle; counts are negedges after driving req.
  task automatic xfer(input bit d, input bit wr, input bit w,
                      input logic [31:0] adr, input logic [31:0] data,
                      output int iss, output int rsp,
                      output logic [31:0] rd, output logic [31:0] oadr,
                      output logic owe, output logic oother,
                      output logic [31:0] owd, output bit both);
    sel = d; iss = -1; rsp = -1; rd = '0; oadr = '0;
    owe = 1'b0; oother = 1'b0; owd = '0; both = 1'b0;
    drive(d, wr, 1'b1, w, adr, data);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (x_rv && x_wf) both = 1'b1;
      if (iss < 0 && (w ? x_ien : x_den)) begin
        iss = c;
        oadr = w ? 32'(x_iadr) : 32'(x_dadr);
        owe = w ? x_iwe : x_dwe;
        oother = w ? (x_den | x_dwe) : (x_ien | x_iwe);
        owd = x_wd;
      end
      if (wr ? x_wf : x_rv) begin
        rsp = c; rd = x_rdata;
        break;
      end
    end
    drive(d, wr, 1'b0, w, adr, data);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({mreq0, ien0, iwe0, den0, dwe0, iadr0, dadr0, wd0, bi0.read_valid,
         bi0.read_data, bi0.write_finish} !== '0) begin
      miscompares++;
      $display("FAIL reset_outs0 got mreq=%b ien=%b den=%b rd=%h wd=%h need all 0",
               mreq0, ien0, den0, bi0.read_data, wd0);
    end
    vectors++;
    if ({mreq3, ien3, iwe3, den3, dwe3, iadr3, dadr3, wd3, bi3.read_valid,
         bi3.read_data, bi3.write_finish} !== '0) begin
      miscompares++;
      $display("FAIL reset_outs3 got mreq=%b ien=%b den=%b rd=%h need all 0",
               mreq3, ien3, den3, bi3.read_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int iss, rsp; logic [31:0] rd, oadr, owd; logic owe, oth; bit both;
    exp_t e;
    gnt0 = 1'b1;
    sb.push_back('{wr: 1'b1, data: 32'hDEADBEEF});
    xfer(0, 1, MEM_SEL_DMEM, 32'h0000_0010, 32'hDEADBEEF,
         iss, rsp, rd, oadr, owe, oth, owd, both);
    e = pop_exp();
    vectors++;
    if (iss !== 1 || owe !== 1'b1 || oadr !== 32'd4 || owd !== 32'hDEADBEEF || oth !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_issue got cyc=%0d we=%b adr=%0d wd=%h other=%b need 1,1,4,deadbeef,0",
               iss, owe, oadr, owd, oth);
    end
    vectors++;
    if (rsp !== 2 || e.wr !== 1'b1 || both) begin
      miscompares++;
      $display("FAIL wr_finish got cyc=%0d kind=%b both=%b need 2,1,0", rsp, e.wr, both);
    end
    sb.push_back('{wr: 1'b0, data: 32'hDEADBEEF});
    xfer(0, 0, MEM_SEL_DMEM, 32'h0000_0010, 32'h0,
         iss, rsp, rd, oadr, owe, oth, owd, both);
    e = pop_exp();
    vectors++;
    if (iss !== 1 || owe !== 1'b0 || oadr !== 32'd4) begin
      miscompares++;
      $display("FAIL rd_issue got cyc=%0d we=%b adr=%0d need 1,0,4", iss, owe, oadr);
    end
    vectors++;
    if (rsp !== 2 || e.wr !== 1'b0 || rd !== e.data) begin
      miscompares++;
      $display("FAIL rd_resp got cyc=%0d data=%h need 2,%h", rsp, rd, e.data);
    end
    sb.push_back('{wr: 1'b1, data: 32'h0BAD_F00D});
    xfer(0, 1, MEM_SEL_DMEM, 32'h0000_0020, 32'h0BAD_F00D,
         iss, rsp, rd, oadr, owe, oth, owd, both);
    e = pop_exp();
    vectors++;
    if (rsp !== 2 || oadr !== 32'd8 || bi0.read_data !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL rd_hold got cyc=%0d adr=%0d read_data=%h need 2,8,deadbeef",
               rsp, oadr, bi0.read_data);
    end
  endtask

  task automatic test_simultaneous();
    int wc, rc; bit both; exp_t e;
    sel = 0; wc = -1; rc = -1; both = 1'b0;
    sb.push_back('{wr: 1'b1, data: 32'h1234_5678});
    sb.push_back('{wr: 1'b0, data: 32'h1234_5678});
    drive(0, 1, 1'b1, MEM_SEL_IMEM, 32'h40, 32'h1234_5678);
    drive(0, 0, 1'b1, MEM_SEL_IMEM, 32'h40, 32'h0);
    for (int c = 1; c <= 30 && rc < 0; c++) begin
      @(negedge clk);
      if (bi0.write_finish && bi0.read_valid) both = 1'b1;
      if (bi0.write_finish) begin
        e = pop_exp(); wc = c;
        vectors++;
        if (e.wr !== 1'b1) begin
          miscompares++;
          $display("FAIL sim_order got write_finish first-kind=%b need 1", e.wr);
        end
        drive(0, 1, 1'b0, MEM_SEL_IMEM, 32'h40, 32'h0);
      end
      if (bi0.read_valid) begin
        e = pop_exp(); rc = c;
        vectors++;
        if (e.wr !== 1'b0 || bi0.read_data !== e.data) begin
          miscompares++;
          $display("FAIL sim_read got kind=%b data=%h need 0,%h", e.wr, bi0.read_data, e.data);
        end
        drive(0, 0, 1'b0, MEM_SEL_IMEM, 32'h40, 32'h0);
      end
    end
    drive(0, 1, 1'b0, MEM_SEL_IMEM, 32'h40, 32'h0);
    drive(0, 0, 1'b0, MEM_SEL_IMEM, 32'h40, 32'h0);
    vectors++;
    if (wc !== 2 || rc !== 6 || both) begin
      miscompares++;
      $display("FAIL sim_timing got wcyc=%0d rcyc=%0d both=%b need 2,6,0", wc, rc, both);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_grant_stall();
    int rc; bit bad; exp_t e;
    sel = 0; gnt0 = 1'b0; rc = -1;
    sb.push_back('{wr: 1'b0, data: 32'h1234_5678});
    drive(0, 0, 1'b1, MEM_SEL_IMEM, 32'h40, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bad = (mreq0 !== 1'b1) || ({ien0, iwe0, den0, dwe0} !== 4'b0)
            || bi0.read_valid !== 1'b0;
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL stall_c%0d got mreq=%b en=%b%b rv=%b need 1,00,0",
                 c, mreq0, ien0, den0, bi0.read_valid);
      end
    end
    gnt0 = 1'b1;
    #1;
    vectors++;
    if (ien0 !== 1'b1 || iwe0 !== 1'b0 || iadr0 !== 14'd16 || mreq0 !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_issue got ien=%b iwe=%b adr=%0d mreq=%b need 1,0,16,1",
               ien0, iwe0, iadr0, mreq0);
    end
    for (int c = 1; c <= 10 && rc < 0; c++) begin
      @(negedge clk);
      if (bi0.read_valid) begin
        rc = c; e = pop_exp();
        vectors++;
        if (bi0.read_data !== e.data || mreq0 !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_data got %h mreq=%b need %h,0", bi0.read_data, mreq0, e.data);
        end
      end
    end
    drive(0, 0, 1'b0, MEM_SEL_IMEM, 32'h40, 32'h0);
    vectors++;
    if (rc !== 1) begin
      miscompares++;
      $display("FAIL stall_resp got cyc=%0d need 1", rc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency3();
    int iss, rsp; logic [31:0] rd, oadr, owd; logic owe, oth; bit both;
    exp_t e;
    gnt3 = 1'b1;
    sb.push_back('{wr: 1'b1, data: 32'hCAFE_0003});
    xfer(1, 1, MEM_SEL_IMEM, 32'h8, 32'hCAFE_0003,
         iss, rsp, rd, oadr, owe, oth, owd, both);
    e = pop_exp();
    vectors++;
    if (rsp !== 2 || e.wr !== 1'b1 || oadr !== 32'd2) begin
      miscompares++;
      $display("FAIL lat3_wr got cyc=%0d adr=%0d need 2,2", rsp, oadr);
    end
    sb.push_back('{wr: 1'b0, data: 32'hCAFE_0003});
    xfer(1, 0, MEM_SEL_IMEM, 32'h8, 32'h0,
         iss, rsp, rd, oadr, owe, oth, owd, both);
    e = pop_exp();
    vectors++;
    if (iss !== 1 || rsp !== 4 || rd !== e.data || both) begin
      miscompares++;
      $display("FAIL lat3_rd got issue=%0d resp=%0d data=%h need 1,4,%h",
               iss, rsp, rd, e.data);
    end
    vectors++;
    if (bi3.read_data !== 32'hCAFE_0003) begin
      miscompares++;
      $display("FAIL lat3_hold got %h need cafe0003", bi3.read_data);
    end
  endtask

  task automatic test_alias();
    int iss, rsp; logic [31:0] rd, oadr, owd; logic owe, oth; bit both;
    exp_t e;
    sb.push_back('{wr: 1'b1, data: 32'hA5A5_5A5A});
    xfer(0, 1, MEM_SEL_IMEM, 32'h0001_0004, 32'hA5A5_5A5A,
         iss, rsp, rd, oadr, owe, oth, owd, both);
    e = pop_exp();
    vectors++;
    if (oadr !== 32'd1 || owe !== 1'b1 || oth !== 1'b0 || rsp !== 2) begin
      miscompares++;
      $display("FAIL alias_wr got adr=%0d we=%b other=%b cyc=%0d need 1,1,0,2",
               oadr, owe, oth, rsp);
    end
    sb.push_back('{wr: 1'b0, data: 32'hA5A5_5A5A});
    xfer(0, 0, MEM_SEL_IMEM, 32'h0000_0007, 32'h0,
         iss, rsp, rd, oadr, owe, oth, owd, both);
    e = pop_exp();
    vectors++;
    if (oadr !== 32'd1 || rd !== e.data) begin
      miscompares++;
      $display("FAIL alias_rd got adr=%0d data=%h need 1,%h", oadr, rd, e.data);
    end
  endtask

  task automatic test_reset_rwait();
    int iss, rsp; logic [31:0] rd, oadr, owd; logic owe, oth; bit both;
    bit seen; exp_t e;
    sel = 1; seen = 1'b0;
    sb.push_back('{wr: 1'b1, data: 32'h7777_0001});
    xfer(1, 1, MEM_SEL_IMEM, 32'hC, 32'h7777_0001,
         iss, rsp, rd, oadr, owe, oth, owd, both);
    e = pop_exp();
    drive(1, 0, 1'b1, MEM_SEL_IMEM, 32'hC, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    drive(1, 0, 1'b0, MEM_SEL_IMEM, 32'hC, 32'h0);
    repeat (4) begin
      @(negedge clk);
      if (bi3.read_valid) seen = 1'b1;
    end
    vectors++;
    if (seen || {mreq3, ien3, iwe3, den3, dwe3, iadr3, dadr3, wd3,
                 bi3.read_data, bi3.write_finish} !== '0) begin
      miscompares++;
      $display("FAIL rst_rwait got rv_seen=%b read_data=%h mreq=%b need 0,0,0",
               seen, bi3.read_data, mreq3);
    end
    rst_n = 1'b1;
    @(negedge clk);
    sb.push_back('{wr: 1'b0, data: 32'h7777_0001});
    xfer(1, 0, MEM_SEL_IMEM, 32'hC, 32'h0,
         iss, rsp, rd, oadr, owe, oth, owd, both);
    e = pop_exp();
    vectors++;
    if (rsp !== 4 || rd !== e.data) begin
      miscompares++;
      $display("FAIL rst_recover got cyc=%0d data=%h need 4,%h", rsp, rd, e.data);
    end
  endtask

  initial begin
    gnt0 = 1'b1; gnt3 = 1'b1;
    drive(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_write_read();
    test_simultaneous();
    test_grant_stall();
    test_latency3();
    test_alias();
    test_reset_rwait();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain got %0d left need 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
